// File: rtl/lsu_pkg.sv
// Shared pipeline definitions for the execute-side LSU and the MEM stage.
// Latency: none (types, encodings and pure decode helpers only).
// Backpressure: not applicable.
package lsu_pkg;

  localparam int XLEN = 32;

  // Memory operation codes carried on the ALU-to-LSU bus
  typedef enum logic [3:0] {
    LS_NONE = 4'd0,
    LS_LB   = 4'd1,
    LS_LH   = 4'd2,
    LS_LW   = 4'd3,
    LS_LBU  = 4'd4,
    LS_LHU  = 4'd5,
    LS_SB   = 4'd9,
    LS_SH   = 4'd10,
    LS_SW   = 4'd11
  } ls_op_e;

  // Load kind forwarded to the MEM stage for extraction and sign extension
  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LH   = 3'd2,
    LD_LW   = 3'd3,
    LD_LBU  = 3'd4,
    LD_LHU  = 3'd5
  } load_inst_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  // Unknown codes collapse to LS_NONE so they behave as a plain pass-through.
  function automatic ls_op_e decode_op(input logic [3:0] raw);
    case (raw)
      4'd1:    return LS_LB;
      4'd2:    return LS_LH;
      4'd3:    return LS_LW;
      4'd4:    return LS_LBU;
      4'd5:    return LS_LHU;
      4'd9:    return LS_SB;
      4'd10:   return LS_SH;
      4'd11:   return LS_SW;
      default: return LS_NONE;
    endcase
  endfunction

  function automatic acc_size_e op_size(input ls_op_e op);
    case (op)
      LS_LB, LS_LBU, LS_SB: return SZ_BYTE;
      LS_LH, LS_LHU, LS_SH: return SZ_HALF;
      LS_LW, LS_SW:         return SZ_WORD;
      default:              return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_store(input ls_op_e op);
    return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
  endfunction

  function automatic logic is_load(input ls_op_e op);
    return (op == LS_LB) || (op == LS_LH) || (op == LS_LW) ||
           (op == LS_LBU) || (op == LS_LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: strobe, replicated store data and misalignment flag.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs directly.
module lsu_align
  import lsu_pkg::*;
(
  input  ls_op_e          op,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  output logic [3:0]      strb,
  output logic [XLEN-1:0] wdata,
  output logic            misaligned
);

  // Size-driven lane selection; data is replicated so any lane holds it
  always_comb begin
    strb       = 4'd0;
    wdata      = store_data;
    misaligned = 1'b0;
    case (op_size(op))
      SZ_BYTE: begin
        strb  = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        strb       = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        strb       = 4'hF;
        misaligned = |addr_lo;
      end
      default: begin
        strb = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_req.sv
// Execute-stage LSU: issues one data-memory request per load/store and forwards the result.
// Latency: 1 cycle for non-memory/misaligned ops; REQ + WAIT + response delay for memory ops.
// Backpressure: holds a single instruction; ready drops until the result is taken downstream.
module lsu_req
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [4+1+ADDR_WIDTH+2*DATA_WIDTH-1:0] alu_to_lsu_bus,
  input  logic                                 alu_to_lsu_valid,
  output logic                                 lsu_to_alu_ready,
  output logic                                 dmem_req_valid,
  input  logic                                 dmem_req_ready,
  output logic                                 dmem_req_wen,
  output logic [DATA_WIDTH-1:0]                dmem_req_addr,
  output logic [3:0]                           dmem_req_wstrb,
  output logic [DATA_WIDTH-1:0]                dmem_req_wdata,
  input  logic                                 dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                dmem_rsp_rdata,
  output logic [2*DATA_WIDTH+ADDR_WIDTH+8-1:0] exe_to_mem_bus,
  output logic                                 exe_to_mem_valid,
  input  logic                                 mem_to_exe_ready,
  output logic                                 misalign_err
);

  localparam int IN_W = 4 + 1 + ADDR_WIDTH + 2 * DATA_WIDTH;

  // Incoming instruction fields
  logic [3:0]            in_op_raw;
  ls_op_e                in_op;
  logic                  in_regw;
  logic [ADDR_WIDTH-1:0] in_reg_addr;
  logic [DATA_WIDTH-1:0] in_alu;
  logic [DATA_WIDTH-1:0] in_sd;

  assign in_op_raw   = alu_to_lsu_bus[IN_W-1 -: 4];
  assign in_regw     = alu_to_lsu_bus[IN_W-5];
  assign in_reg_addr = alu_to_lsu_bus[2*DATA_WIDTH +: ADDR_WIDTH];
  assign in_alu      = alu_to_lsu_bus[DATA_WIDTH +: DATA_WIDTH];
  assign in_sd       = alu_to_lsu_bus[DATA_WIDTH-1:0];
  assign in_op       = decode_op(in_op_raw);

  // Alignment helpers
  logic [3:0]      al_strb;
  logic [XLEN-1:0] al_wdata;
  logic            al_misaligned;

  lsu_align u_align (
    .op         (in_op),
    .addr_lo    (in_alu[1:0]),
    .store_data (in_sd),
    .strb       (al_strb),
    .wdata      (al_wdata),
    .misaligned (al_misaligned)
  );

  // State and payload registers
  lsu_state_e            state_q,     state_d;
  logic                  req_vld_q,   req_vld_d;
  logic                  out_vld_q,   out_vld_d;
  logic                  misalign_q,  misalign_d;
  logic                  req_wen_q,   req_wen_d;
  logic [DATA_WIDTH-1:0] req_addr_q,  req_addr_d;
  logic [3:0]            req_wstrb_q, req_wstrb_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  load_inst_e            ld_inst_q,   ld_inst_d;
  logic                  regw_q,      regw_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q,  reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_data_q,  reg_data_d;
  logic [3:0]            ld_strb_q,   ld_strb_d;
  logic [DATA_WIDTH-1:0] ld_data_q,   ld_data_d;

  logic accept;
  logic in_mem;
  logic in_bad;
  logic in_is_ld;

  // Acceptance is possible when empty or when the finished result leaves this cycle
  always_comb begin
    lsu_to_alu_ready = (state_q == ST_IDLE) ||
                       ((state_q == ST_DONE) && mem_to_exe_ready);
    accept   = alu_to_lsu_valid && lsu_to_alu_ready;
    in_mem   = (in_op != LS_NONE);
    in_bad   = in_mem && al_misaligned;
    in_is_ld = is_load(in_op) && !in_bad;
  end

  // Next-state and payload computation; reset overrides the control state only
  always_comb begin
    state_d     = state_q;
    misalign_d  = 1'b0;
    req_wen_d   = req_wen_q;
    req_addr_d  = req_addr_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    ld_inst_d   = ld_inst_q;
    regw_d      = regw_q;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    ld_strb_d   = ld_strb_q;
    ld_data_d   = ld_data_q;

    case (state_q)
      ST_REQ: begin
        if (dmem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d = ST_DONE;
          // Store acknowledges carry no payload for the MEM stage
          if (ld_inst_q != LD_NONE) ld_data_d = dmem_rsp_rdata;
        end
      end
      ST_DONE: begin
        if (mem_to_exe_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (accept) begin
      state_d     = (in_mem && !in_bad) ? ST_REQ : ST_DONE;
      misalign_d  = in_bad;
      req_wen_d   = is_store(in_op);
      req_addr_d  = {in_alu[DATA_WIDTH-1:2], 2'b00};
      req_wstrb_d = al_strb;
      req_wdata_d = al_wdata;
      ld_inst_d   = in_is_ld ? load_inst_e'(in_op_raw[2:0]) : LD_NONE;
      regw_d      = in_regw && !is_store(in_op) && !in_bad;
      reg_addr_d  = in_reg_addr;
      reg_data_d  = in_alu;
      ld_strb_d   = in_is_ld ? al_strb : 4'd0;
      ld_data_d   = '0;
    end

    req_vld_d = (state_d == ST_REQ);
    out_vld_d = (state_d == ST_DONE);

    if (!rst) begin
      state_d    = ST_IDLE;
      req_vld_d  = 1'b0;
      out_vld_d  = 1'b0;
      misalign_d = 1'b0;
    end
  end

  // Register everything on the rising edge
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    req_vld_q   <= req_vld_d;
    out_vld_q   <= out_vld_d;
    misalign_q  <= misalign_d;
    req_wen_q   <= req_wen_d;
    req_addr_q  <= req_addr_d;
    req_wstrb_q <= req_wstrb_d;
    req_wdata_q <= req_wdata_d;
    ld_inst_q   <= ld_inst_d;
    regw_q      <= regw_d;
    reg_addr_q  <= reg_addr_d;
    reg_data_q  <= reg_data_d;
    ld_strb_q   <= ld_strb_d;
    ld_data_q   <= ld_data_d;
  end

  assign dmem_req_valid   = req_vld_q;
  assign dmem_req_wen     = req_wen_q;
  assign dmem_req_addr    = req_addr_q;
  assign dmem_req_wstrb   = req_wstrb_q;
  assign dmem_req_wdata   = req_wdata_q;
  assign exe_to_mem_valid = out_vld_q;
  assign misalign_err     = misalign_q;
  assign exe_to_mem_bus   = {ld_inst_q, regw_q, reg_addr_q, reg_data_q, ld_strb_q, ld_data_q};

endmodule

// File: tb/tb_lsu_req.sv
// Directed bench for lsu_req with hand-computed expectations.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: exercised by holding dmem_req_ready and mem_to_exe_ready low.
module tb_lsu_req;

  logic        clk;
  logic        rst;
  logic [73:0] in_bus;
  logic        in_vld;
  logic        in_rdy;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_vld;
  logic [31:0] rsp_dat;
  logic [76:0] out_bus;
  logic        out_vld;
  logic        out_rdy;
  logic        mis_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  lsu_req #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .alu_to_lsu_bus   (in_bus),
    .alu_to_lsu_valid (in_vld),
    .lsu_to_alu_ready (in_rdy),
    .dmem_req_valid   (req_vld),
    .dmem_req_ready   (req_rdy),
    .dmem_req_wen     (req_wen),
    .dmem_req_addr    (req_addr),
    .dmem_req_wstrb   (req_wstrb),
    .dmem_req_wdata   (req_wdata),
    .dmem_rsp_valid   (rsp_vld),
    .dmem_rsp_rdata   (rsp_dat),
    .exe_to_mem_bus   (out_bus),
    .exe_to_mem_valid (out_vld),
    .mem_to_exe_ready (out_rdy),
    .misalign_err     (mis_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [73:0] mk_in(input logic [3:0] op, input logic rw,
                                        input logic [4:0] ra, input logic [31:0] alu,
                                        input logic [31:0] sd);
    return {op, rw, ra, alu, sd};
  endfunction

  function automatic logic [76:0] ob(input logic [2:0] inst, input logic rw,
                                     input logic [4:0] ra, input logic [31:0] rd,
                                     input logic [3:0] strb, input logic [31:0] data);
    return {inst, rw, ra, rd, strb, data};
  endfunction

  // One instruction from IDLE with an always-ready memory answering right after the request
  task automatic xact(input string tag, input logic [73:0] ib, input logic [31:0] rdata,
                      input logic exp_req, input logic exp_wen, input logic [3:0] exp_strb,
                      input logic [31:0] exp_wdata, input logic [76:0] exp_out);
    logic done;
    logic saw;
    done = 1'b0;
    saw  = 1'b0;
    @(negedge clk);
    in_vld  = 1'b1;
    in_bus  = ib;
    req_rdy = 1'b1;
    out_rdy = 1'b1;
    rsp_dat = rdata;
    @(negedge clk);
    in_vld = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (out_vld) begin
        chk({tag, "_out"}, out_bus, exp_out);
        done = 1'b1;
      end else begin
        if (req_vld) begin
          saw = 1'b1;
          chk({tag, "_wen"}, req_wen, exp_wen);
          chk({tag, "_strb"}, req_wstrb, exp_strb);
          if (exp_wen) chk({tag, "_wdata"}, req_wdata, exp_wdata);
          rsp_vld = 1'b1;
        end
        @(negedge clk);
      end
    end
    rsp_vld = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_req"}, saw, exp_req);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    in_vld  = 1'b0;
    in_bus  = '0;
    req_rdy = 1'b0;
    rsp_vld = 1'b0;
    rsp_dat = '0;
    out_rdy = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_vld", req_vld, 1'b0);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_misalign", mis_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_rdy", in_rdy, 1'b1);

    // No-op passes through in one cycle without touching memory
    xact("nop", mk_in(4'd0, 1'b1, 5'd5, 32'h1234, 32'h0), 32'h0,
         1'b0, 1'b0, 4'h0, 32'h0, ob(3'd0, 1'b1, 5'd5, 32'h1234, 4'h0, 32'h0));

    // lb at 0x1002, response two cycles after the request is taken
    @(negedge clk);
    in_vld  = 1'b1;
    in_bus  = mk_in(4'd1, 1'b1, 5'd7, 32'h1002, 32'h0);
    req_rdy = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    chk("lb_req_vld", req_vld, 1'b1);
    chk("lb_addr", req_addr, 32'h1000);
    chk("lb_wstrb", req_wstrb, 4'h4);
    chk("lb_wen", req_wen, 1'b0);
    @(negedge clk);
    req_rdy = 1'b0;
    chk("lb_req_drop", req_vld, 1'b0);
    @(negedge clk);
    rsp_vld = 1'b1;
    rsp_dat = 32'h80FF0000;
    @(negedge clk);
    rsp_vld = 1'b0;
    chk("lb_out_vld", out_vld, 1'b1);
    chk("lb_out", out_bus, ob(3'd1, 1'b1, 5'd7, 32'h1002, 4'h4, 32'h80FF0000));
    @(negedge clk);

    // sh at 0x2002 with the memory stalling for three cycles
    in_vld  = 1'b1;
    in_bus  = mk_in(4'd10, 1'b1, 5'd8, 32'h2002, 32'h0000BEEF);
    req_rdy = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_req_hold", {req_vld, req_wen, req_addr, req_wstrb, req_wdata},
          {1'b1, 1'b1, 32'h2000, 4'hC, 32'hBEEFBEEF});
      @(negedge clk);
    end
    req_rdy = 1'b1;
    @(negedge clk);
    req_rdy = 1'b0;
    chk("sh_req_drop", req_vld, 1'b0);
    rsp_vld = 1'b1;
    rsp_dat = 32'hDEADBEEF;
    @(negedge clk);
    rsp_vld = 1'b0;
    chk("sh_out_vld", out_vld, 1'b1);
    chk("sh_out", out_bus, ob(3'd0, 1'b0, 5'd8, 32'h2002, 4'h0, 32'h0));
    @(negedge clk);

    // Misaligned lw, then the result is held by downstream backpressure
    in_vld  = 1'b1;
    in_bus  = mk_in(4'd3, 1'b1, 5'd3, 32'h3001, 32'h0);
    out_rdy = 1'b0;
    @(negedge clk);
    in_vld = 1'b0;
    chk("mis_err_pulse", mis_err, 1'b1);
    chk("mis_no_req", req_vld, 1'b0);
    chk("mis_out_vld", out_vld, 1'b1);
    chk("mis_out", out_bus, ob(3'd0, 1'b0, 5'd3, 32'h3001, 4'h0, 32'h0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mis_err_clear", mis_err, 1'b0);
      chk("hold_out", {out_vld, out_bus}, {1'b1, ob(3'd0, 1'b0, 5'd3, 32'h3001, 4'h0, 32'h0)});
      chk("hold_rdy", in_rdy, 1'b0);
    end
    in_vld  = 1'b1;
    in_bus  = mk_in(4'd0, 1'b1, 5'd9, 32'h55, 32'h0);
    out_rdy = 1'b1;
    #1;
    chk("b2b_rdy", in_rdy, 1'b1);
    @(negedge clk);
    in_vld = 1'b0;
    chk("b2b_out_vld", out_vld, 1'b1);
    chk("b2b_out", out_bus, ob(3'd0, 1'b1, 5'd9, 32'h55, 4'h0, 32'h0));
    @(negedge clk);
    chk("b2b_drain", out_vld, 1'b0);

    // More lane patterns and an undefined opcode
    xact("sb", mk_in(4'd9, 1'b1, 5'd2, 32'h5003, 32'h12345678), 32'h0,
         1'b1, 1'b1, 4'h8, 32'h78787878, ob(3'd0, 1'b0, 5'd2, 32'h5003, 4'h0, 32'h0));
    xact("lhu", mk_in(4'd5, 1'b1, 5'd4, 32'h6002, 32'h0), 32'hABCD0000,
         1'b1, 1'b0, 4'hC, 32'h0, ob(3'd5, 1'b1, 5'd4, 32'h6002, 4'hC, 32'hABCD0000));
    xact("illegal", mk_in(4'd7, 1'b1, 5'd6, 32'h77, 32'h0), 32'h0,
         1'b0, 1'b0, 4'h0, 32'h0, ob(3'd0, 1'b1, 5'd6, 32'h77, 4'h0, 32'h0));

    // Reset during WAIT abandons the op; a late response is ignored
    @(negedge clk);
    in_vld  = 1'b1;
    in_bus  = mk_in(4'd3, 1'b1, 5'd1, 32'h4000, 32'h0);
    req_rdy = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    chk("rstw_req_vld", req_vld, 1'b1);
    @(negedge clk);
    req_rdy = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    rst     = 1'b1;
    rsp_vld = 1'b1;
    rsp_dat = 32'h11111111;
    chk("rstw_out_vld", out_vld, 1'b0);
    chk("rstw_req_idle", req_vld, 1'b0);
    chk("rstw_rdy", in_rdy, 1'b1);
    @(negedge clk);
    rsp_vld = 1'b0;
    chk("rstw_late_rsp", out_vld, 1'b0);
    chk("rstw_idle_rdy", in_rdy, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_req.md
LSU_REQ -- requirements
Module: lsu_req

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL be the register-file index width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL be the data and address width; only 32 is supported.
REQ-003 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 alu_to_lsu_bus  in  4+1+ADDR_WIDTH+2*DATA_WIDTH  fields SHALL be, MSB first: {ls_op[3:0], regW, regAddr, alu_result, store_data}.
REQ-006 alu_to_lsu_valid  in  1  upstream instruction valid.
REQ-007 lsu_to_alu_ready  out  1  stage can accept an instruction this cycle.
REQ-008 dmem_req_valid / dmem_req_ready  out/in  1/1  data-memory request handshake.
REQ-009 dmem_req_wen  out  1  1 means store.
REQ-010 dmem_req_addr  out  DATA_WIDTH  word-aligned address, alu_result with bits [1:0] zeroed.
REQ-011 dmem_req_wstrb / dmem_req_wdata  out  4/DATA_WIDTH  byte strobe and lane-aligned store data.
REQ-012 dmem_rsp_valid / dmem_rsp_rdata  in  1/DATA_WIDTH  response, one per request (store acknowledge or load data).
REQ-013 exe_to_mem_bus  out  2*DATA_WIDTH+ADDR_WIDTH+8  SHALL be, MSB first: {load_inst[2:0], regW, regAddr, regData, load_strb[3:0], load_data}.
REQ-014 exe_to_mem_valid / mem_to_exe_ready  out/in  1/1  downstream handshake.
REQ-015 misalign_err  out  1  single-cycle pulse on acceptance of a misaligned memory op.

Function
REQ-016 ls_op encoding SHALL be: 0 none; load 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu; store 9 sb, 10 sh, 11 sw; all other codes SHALL be treated as 0.
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and DONE, and SHALL hold at most one instruction.
REQ-018 lsu_to_alu_ready SHALL be (state==IDLE) | (state==DONE & mem_to_exe_ready).
REQ-019 An accepted instruction with ls_op 0 or a misaligned op SHALL go to DONE next cycle (1-cycle latency) without any memory access.
REQ-020 An accepted aligned memory op SHALL go to REQ, with dmem_req_valid=1 and all dmem_req_* fields held stable until dmem_req_ready=1.
REQ-021 REQ with dmem_req_ready=1 SHALL go to WAIT; WAIT with dmem_rsp_valid=1 SHALL capture dmem_rsp_rdata and go to DONE.
REQ-022 dmem_rsp_valid SHALL be ignored in IDLE, REQ and DONE.
REQ-023 exe_to_mem_valid SHALL be (state==DONE); output fields SHALL remain stable while valid=1 and ready=0.
REQ-024 DONE with mem_to_exe_ready=1 SHALL go to IDLE, or directly to REQ/DONE if a new instruction is accepted in the same cycle (back-to-back, no bubble).
REQ-025 Misaligned SHALL mean halfword op with addr[0]=1, or word op with addr[1:0]!=0.
REQ-026 Strobe SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'hF.
REQ-027 wdata SHALL be: sb {4{d[7:0]}}, sh {2{d[15:0]}}, sw d.
REQ-028 Output for a load SHALL be load_inst=ls_op[2:0], regW and regAddr passed through, regData=alu_result, load_strb=strobe, load_data=captured rdata.
REQ-029 Output for a store, ls_op 0, or a misaligned op SHALL be load_inst=0, load_strb=0, load_data=0, regData=alu_result.
REQ-030 regW SHALL be forced to 0 for stores and misaligned ops, and passed through for ls_op 0.
REQ-031 misalign_err SHALL be 1 for exactly the cycle after acceptance of a misaligned op.

Reset
REQ-032 While rst=0, the block SHALL force state=IDLE and drive dmem_req_valid=0, exe_to_mem_valid=0 and misalign_err=0.
REQ-033 Asserting rst=0 during REQ or WAIT SHALL abandon the instruction with no output; payload registers need no reset.

Structure
REQ-034 ls_op codes, load_inst codes and FSM state encodings SHALL live in a shared pipeline package also used by the MEM stage.
REQ-035 Strobe, wdata and misalign generation SHALL be one combinational sub-module, lsu_align.

Verification
REQ-036 ls_op=0, alu_result=0x1234, regW=1, regAddr=5, ready=1 -> exe_to_mem_valid=1 next cycle with regData=0x1234, load_inst=0, no dmem_req_valid.
REQ-037 lb at addr 0x1002, req_ready=1 immediately, rsp after 2 cycles with rdata 0x80FF0000 -> dmem_req_addr=0x1000, wstrb=4'h4; output load_inst=1, load_strb=4'h4, load_data=0x80FF0000.
REQ-038 sh d=0xBEEF at addr 0x2002, req_ready held 0 for 3 cycles -> request fields stable throughout; wdata=0xBEEFBEEF, wstrb=4'hC; output regW=0.
REQ-039 lw at addr 0x3001 -> misalign_err pulses once, no request issued, output regW=0 and load_inst=0.
REQ-040 Output held with mem_to_exe_ready=0 for 4 cycles -> bus stable and lsu_to_alu_ready=0; on ready=1 the next op is accepted in the same cycle.
REQ-041 rst=0 asserted in WAIT, then a late dmem_rsp_valid -> no output, state IDLE, rsp ignored.
